fpu_divsqrt_iter: RTL and testbench

Multi-cycle IEEE-754 divide and square-root unit for the RV32F datapath. It adds FDIV.S and FSQRT.S to the single-cycle combinational FPU ops and is the first FPU block that can raise DZ. The unit uses a radix-2 restoring digit recurrence, generic in exponent/mantissa width, with a start/busy/done handshake so the pipeline stalls while it iterates. Results and fflags go to the same writeback/fcsr path as the other FPU ops.

---
 rtl/fpu_divsqrt_iter.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_fpu_divsqrt_iter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_divsqrt_iter.sv
// Multi-cycle IEEE-754 divide / square-root unit using a radix-2 restoring digit recurrence.
// Handshake is start/busy/done. The result and fflags stay held until the next operation completes.
module fpu_divsqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int ITER  = MAN_W + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 kill,
    input  logic                 op_sqrt,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [2:0]           frm,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 NV,
    output logic                 DZ,
    output logic                 OF,
    output logic                 UF,
    output logic                 NX
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 3;
    localparam int SW    = MAN_W + 1;
    localparam int RW    = ITER + 2;
    localparam int XW    = 2 * ITER;
    localparam int SQ_SH = 2 * (ITER - 1) - MAN_W;
    localparam int CW    = $clog2(ITER);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int EMAXF = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAXF_S = EW'(EMAXF);
    localparam logic signed [EW-1:0] ONE_S   = EW'(1);
    localparam logic signed [EW-1:0] CAP_S   = EW'(SW + 2);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         res_q, res_d;
    logic [4:0]           flg_q, flg_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic                 op_q, op_d;
    logic [2:0]           frm_q, frm_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [ITER-1:0]      quo_q, quo_d;
    logic [SW-1:0]        dvs_q, dvs_d;
    logic [XW-1:0]        rad_q, rad_d;

    function automatic int lzc(input logic [SW-1:0] m);
        int  n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (m[i]) hit = 1'b1;
            else if (!hit) n = n + 1;
        end
        return n;
    endfunction

    function automatic logic [SW-1:0] op_sig(input logic [W-1:0] x);
        logic [SW-1:0] m;
        m = {|x[W-2:MAN_W], x[MAN_W-1:0]};
        return m << lzc(m);
    endfunction

    // Subnormals share the exponent of the smallest normal, minus their leading-zero count.
    function automatic logic signed [EW-1:0] op_exp(input logic [W-1:0] x);
        logic [EXP_W-1:0] ef;
        ef = x[W-2:MAN_W];
        if (ef == '0) ef = EXP_W'(1);
        return $signed(EW'(ef)) - BIAS_S - $signed(EW'(lzc({|x[W-2:MAN_W], x[MAN_W-1:0]})));
    endfunction

    function automatic logic round_up(input logic [2:0] rm, input logic s, input logic lsb,
                                      input logic g, input logic rs);
        case (rm)
            3'b001:  round_up = 1'b0;
            3'b010:  round_up = s & (g | rs);
            3'b011:  round_up = !s & (g | rs);
            3'b100:  round_up = g;
            default: round_up = g & (rs | lsb);
        endcase
    endfunction

    function automatic logic [W-1:0] ovf_res(input logic [2:0] rm, input logic s);
        logic to_inf;
        case (rm)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = s;
            3'b011:  to_inf = !s;
            default: to_inf = 1'b1;
        endcase
        return to_inf ? {s, INF} : {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    endfunction

    logic                 a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
    logic [SW-1:0]        sa, sb;
    logic signed [EW-1:0] ea, eb;

    assign a_zero = (a_q[W-2:0] == '0);
    assign b_zero = (b_q[W-2:0] == '0);
    assign a_inf  = (a_q[W-2:0] == INF);
    assign b_inf  = (b_q[W-2:0] == INF);
    assign a_nan  = (&a_q[W-2:MAN_W]) && (a_q[MAN_W-1:0] != '0);
    assign b_nan  = (&b_q[W-2:MAN_W]) && (b_q[MAN_W-1:0] != '0);
    assign a_snan = a_nan && !a_q[MAN_W-1];
    assign b_snan = b_nan && !b_q[MAN_W-1];
    assign sa     = op_sig(a_q);
    assign sb     = op_sig(b_q);
    assign ea     = op_exp(a_q);
    assign eb     = op_exp(b_q);

    logic                 lead, g0, r0, s0, dnrm, g1, r1, s1, up, inexact, tiny, of;
    logic [ITER-1:0]      nq;
    logic [SW-1:0]        sig0;
    logic signed [EW-1:0] be, sh, ebase, efin;
    logic [SW+1:0]        v, mask;
    logic [SW:0]          sum;
    logic [MAN_W-1:0]     frac;

    // Round stage: normalise by one bit, denormalise below the minimum exponent, then round.
    always_comb begin
        lead  = quo_q[ITER-1];
        nq    = lead ? quo_q : {quo_q[ITER-2:0], 1'b0};
        be    = lead ? exp_q + BIAS_S : exp_q + BIAS_S - ONE_S;
        sig0  = nq[ITER-1 -: SW];
        g0    = nq[ITER-1-SW];
        r0    = nq[ITER-2-SW];
        s0    = (|nq[ITER-3-SW:0]) | (|rem_q);
        dnrm  = (be < ONE_S);
        sh    = ONE_S - be;
        if (sh > CAP_S) sh = CAP_S;
        v     = {sig0, g0, r0};
        mask  = '0;
        ebase = be;
        s1    = s0;
        if (dnrm) begin
            mask  = ~({(SW+2){1'b1}} << sh);
            s1    = s0 | (|(v & mask));
            v     = v >> sh;
            ebase = ONE_S;
        end
        g1      = v[1];
        r1      = v[0];
        up      = round_up(frm_q, sign_q, v[2], g1, r1 | s1);
        inexact = g1 | r1 | s1;
        sum     = {1'b0, v[SW+1:2]} + (SW+1)'(up);
        if (sum[SW]) begin
            efin = ebase + ONE_S;
            frac = sum[MAN_W:1];
        end else if (sum[SW-1]) begin
            efin = ebase;
            frac = sum[MAN_W-1:0];
        end else begin
            efin = '0;
            frac = sum[MAN_W-1:0];
        end
        of   = (efin >= EMAXF_S);
        // Tiny unless rounding with an unbounded exponent would have carried up to the minimum normal.
        tiny = dnrm && !((be == '0) && (&sig0) && round_up(frm_q, sign_q, sig0[0], g0, r0 | s0));
    end

    logic [RW+1:0] t_sq, c_sq;
    logic          spec;
    logic [W-1:0]  spec_res;
    logic [4:0]    spec_flg;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        flg_d    = flg_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        frm_d    = frm_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rad_d    = rad_q;
        t_sq     = '0;
        c_sq     = '0;
        spec     = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_sqrt;
                    frm_d   = frm;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                cnt_d = '0;
                quo_d = '0;
                if (!op_q) begin
                    if (a_nan || b_nan) begin
                        spec_res = QNAN;
                        spec_flg = {a_snan | b_snan, 4'b0};
                    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        spec_res = QNAN;
                        spec_flg = 5'b10000;
                    end else if (a_inf) begin
                        spec_res = {a_q[W-1] ^ b_q[W-1], INF};
                    end else if (b_inf || a_zero) begin
                        spec_res = {a_q[W-1] ^ b_q[W-1], {(W-1){1'b0}}};
                    end else if (b_zero) begin
                        spec_res = {a_q[W-1] ^ b_q[W-1], INF};
                        spec_flg = 5'b01000;
                    end else begin
                        spec = 1'b0;
                    end
                end else begin
                    if (a_nan) begin
                        spec_res = QNAN;
                        spec_flg = {a_snan, 4'b0};
                    end else if (a_zero) begin
                        spec_res = a_q;
                    end else if (a_q[W-1]) begin
                        spec_res = QNAN;
                        spec_flg = 5'b10000;
                    end else if (a_inf) begin
                        spec_res = a_q;
                    end else begin
                        spec = 1'b0;
                    end
                end
                if (spec) begin
                    res_d   = spec_res;
                    flg_d   = spec_flg;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                    if (op_q) begin
                        // Odd exponent: fold one factor of two into the radicand so the exponent halves exactly.
                        sign_d = 1'b0;
                        exp_d  = ea >>> 1;
                        rem_d  = '0;
                        rad_d  = XW'(ea[0] ? {sa, 1'b0} : {1'b0, sa}) << SQ_SH;
                    end else begin
                        sign_d = a_q[W-1] ^ b_q[W-1];
                        exp_d  = ea - eb;
                        rem_d  = RW'(sa);
                        dvs_d  = sb;
                    end
                end
            end
            S_ITER: begin
                if (op_q) begin
                    t_sq = {rem_q, rad_q[XW-1 -: 2]};
                    c_sq = (RW+2)'({quo_q, 2'b01});
                    if (t_sq >= c_sq) begin
                        rem_d = RW'(t_sq - c_sq);
                        quo_d = {quo_q[ITER-2:0], 1'b1};
                    end else begin
                        rem_d = RW'(t_sq);
                        quo_d = {quo_q[ITER-2:0], 1'b0};
                    end
                    rad_d = rad_q << 2;
                end else begin
                    if (rem_q >= RW'(dvs_q)) begin
                        rem_d = (rem_q - RW'(dvs_q)) << 1;
                        quo_d = {quo_q[ITER-2:0], 1'b1};
                    end else begin
                        rem_d = rem_q << 1;
                        quo_d = {quo_q[ITER-2:0], 1'b0};
                    end
                end
                if (cnt_q == CW'(ITER - 1)) state_d = S_ROUND;
                else cnt_d = cnt_q + 1'b1;
            end
            S_ROUND: begin
                res_d   = of ? ovf_res(frm_q, sign_q) : {sign_q, efin[EXP_W-1:0], frac};
                flg_d   = {2'b00, of, tiny & inexact, inexact | of};
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (kill && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            res_d   = res_q;
            flg_d   = flg_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        op_q   <= op_d;
        frm_q  <= frm_d;
        sign_q <= sign_d;
        exp_q  <= exp_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        rad_q  <= rad_d;
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = res_q;
    assign {NV, DZ, OF, UF, NX} = flg_q;

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Directed bench for fpu_divsqrt_iter: hand-computed single-precision results, flags, latency and control.
module tb_fpu_divsqrt_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic        op_sqrt = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  frm = 3'b000;
    logic        busy, done, NV, DZ, OF, UF, NX;
    logic [31:0] result;
    logic [4:0]  flg;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_divsqrt_iter dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .op_sqrt(op_sqrt),
        .a(a), .b(b), .frm(frm), .busy(busy), .done(done), .result(result),
        .NV(NV), .DZ(DZ), .OF(OF), .UF(UF), .NX(NX)
    );

    assign flg = {NV, DZ, OF, UF, NX};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch in the next cycle, wait for done, then check latency, busy span, result and flags.
    task automatic run_op(input string tag, input logic sq, input logic [31:0] va, input logic [31:0] vb,
                          input logic [2:0] rm, input int exp_lat, input logic [31:0] exp_res,
                          input logic [4:0] exp_flg);
        int lat;
        int bcnt;
        @(negedge clk);
        op_sqrt = sq;
        a       = va;
        b       = vb;
        frm     = rm;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) bcnt++;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, bcnt, exp_lat);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " flags"}, {27'b0, flg}, {27'b0, exp_flg});
    endtask

    initial begin
        int lat;
        int dones;

        repeat (2) @(negedge clk);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst result", result, 32'h0);
        chk("rst flags", {27'b0, flg}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst busy", {31'b0, busy}, 32'd0);

        run_op("6/2 rne", 1'b0, 32'h40C00000, 32'h40000000, 3'b000, 30, 32'h40400000, 5'b00000);
        run_op("1/3 rne", 1'b0, 32'h3F800000, 32'h40400000, 3'b000, 30, 32'h3EAAAAAB, 5'b00001);
        run_op("1/3 rtz", 1'b0, 32'h3F800000, 32'h40400000, 3'b001, 30, 32'h3EAAAAAA, 5'b00001);
        run_op("1/+0", 1'b0, 32'h3F800000, 32'h00000000, 3'b000, 2, 32'h7F800000, 5'b01000);
        run_op("0/0", 1'b0, 32'h00000000, 32'h00000000, 3'b000, 2, 32'h7FC00000, 5'b10000);
        run_op("snan/1", 1'b0, 32'h7F800001, 32'h3F800000, 3'b000, 2, 32'h7FC00000, 5'b10000);
        run_op("qnan/1", 1'b0, 32'h7FC00000, 32'h3F800000, 3'b000, 2, 32'h7FC00000, 5'b00000);
        run_op("sqrt -1", 1'b1, 32'hBF800000, 32'h0, 3'b000, 2, 32'h7FC00000, 5'b10000);
        run_op("sqrt -0", 1'b1, 32'h80000000, 32'h0, 3'b000, 2, 32'h80000000, 5'b00000);
        run_op("sqrt +inf", 1'b1, 32'h7F800000, 32'h0, 3'b000, 2, 32'h7F800000, 5'b00000);
        run_op("sqrt2 rne", 1'b1, 32'h40000000, 32'h0, 3'b000, 30, 32'h3FB504F3, 5'b00001);
        run_op("sqrt2 rtz", 1'b1, 32'h40000000, 32'h0, 3'b001, 30, 32'h3FB504F3, 5'b00001);
        run_op("sqrt2 rup", 1'b1, 32'h40000000, 32'h0, 3'b011, 30, 32'h3FB504F4, 5'b00001);
        run_op("sqrt4", 1'b1, 32'h40800000, 32'h0, 3'b000, 30, 32'h40000000, 5'b00000);
        run_op("ovf rne", 1'b0, 32'h7F7FFFFF, 32'h3F000000, 3'b000, 30, 32'h7F800000, 5'b00101);
        run_op("ovf rtz", 1'b0, 32'h7F7FFFFF, 32'h3F000000, 3'b001, 30, 32'h7F7FFFFF, 5'b00101);
        run_op("subn exact", 1'b0, 32'h00800000, 32'h40000000, 3'b000, 30, 32'h00400000, 5'b00000);
        run_op("subn tie", 1'b0, 32'h00800001, 32'h40000000, 3'b000, 30, 32'h00400000, 5'b00011);

        // kill at iteration 10: no done, held result and flags survive
        @(negedge clk);
        op_sqrt = 1'b0;
        a       = 32'h40C00000;
        b       = 32'h40000000;
        frm     = 3'b000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill busy", {31'b0, busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("kill no done", dones, 32'd0);
        chk("kill result", result, 32'h00400000);
        chk("kill flags", {27'b0, flg}, 32'h00000003);

        // kill together with start in IDLE
        start = 1'b1;
        kill  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        chk("kill+start busy", {31'b0, busy}, 32'd0);

        // start pulsed while busy and during DONE is ignored
        @(negedge clk);
        a     = 32'h40C00000;
        b     = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        a     = 32'h3F800000;
        b     = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("busy-start latency", lat, 32'd30);
        chk("busy-start result", result, 32'h40400000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done-start busy", {31'b0, busy}, 32'd0);

        // asynchronous reset in the middle of the recurrence
        @(negedge clk);
        a     = 32'h3F800000;
        b     = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst busy", {31'b0, busy}, 32'd0);
        chk("arst done", {31'b0, done}, 32'd0);
        chk("arst result", result, 32'h0);
        chk("arst flags", {27'b0, flg}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("6/2 after rst", 1'b0, 32'h40C00000, 32'h40000000, 3'b000, 30, 32'h40400000, 5'b00000);
        run_op("b2b 1/3 rne", 1'b0, 32'h3F800000, 32'h40400000, 3'b000, 30, 32'h3EAAAAAB, 5'b00001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
